la_data_bus: RTL and testbench
==============================

LA_DATA_BUS -- requirements
Module: la_data_bus

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter NUM_SLV, default 4, number of slave channels, 2..8.
REQ-004 SHALL have parameter SEL_LSB, default 28, LSB of the slave-index field in the address.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for a slave ack, 1..65535.
REQ-006 SHALL have the port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have the port rst, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have the port cpu_en_i, input, 1, CPU data-access request.
REQ-009 SHALL have the port cpu_we_i, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have the port cpu_addr_i, input, ADDR_W, byte address.
REQ-011 SHALL have the port cpu_sel_i, input, DATA_W/8, byte enables.
REQ-012 SHALL have the port cpu_wdata_i, input, DATA_W, write data.
REQ-013 SHALL have the port cpu_rdata_o, output, DATA_W, read data.
REQ-014 SHALL have the port cpu_stall_o, output, 1, CPU pipeline hold.
REQ-015 SHALL have the port cpu_err_o, output, 1, bus error, valid with completion.
REQ-016 SHALL have the port slv_req_o, output, NUM_SLV, one-hot per-slave request.
REQ-017 SHALL have the ports slv_we_o (1), slv_addr_o (ADDR_W), slv_sel_o (DATA_W/8) and slv_wdata_o (DATA_W), outputs, shared by all slaves.
REQ-018 SHALL have the port slv_rdata_i, input, NUM_SLV*DATA_W, slave k read data in bits [k*DATA_W +: DATA_W].
REQ-019 SHALL have the port slv_ack_i, input, NUM_SLV, per-slave completion.

Function
REQ-020 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-021 SHALL, in IDLE with cpu_en_i=1, latch we/addr/sel/wdata and decode idx = cpu_addr_i[SEL_LSB +: clog2(NUM_SLV)].
REQ-022 SHALL go from IDLE to ACCESS when idx < NUM_SLV; otherwise SHALL go to DONE with err=1 and rdata=0 (decode error).
REQ-023 SHALL, in ACCESS, hold slv_req_o[idx]=1 (all other bits 0) and drive the slv_* fields from the latched values, stable until exit.
REQ-024 SHALL, in ACCESS on slv_ack_i[idx]=1, latch rdata from slave idx for a read (0 for a write), set err=0, and go to DONE.
REQ-025 SHALL, in ACCESS, count wait cycles from 0 on entry, and at count == TIMEOUT-1 without ack SHALL go to DONE with err=1 and rdata=0.
REQ-026 SHALL, in DONE, drive cpu_rdata_o and cpu_err_o from the latched values for exactly one cycle, then go to IDLE.
REQ-027 SHALL make cpu_stall_o combinational: 1 when (IDLE and cpu_en_i) or ACCESS, and 0 in DONE.
REQ-028 SHALL drive cpu_rdata_o=0 and cpu_err_o=0 outside DONE.
REQ-029 SHALL give a minimum latency of request in cycle 0 (IDLE), ack in cycle 1 (ACCESS), completion in cycle 2 (DONE, stall=0).
REQ-030 SHALL ignore slv_ack_i outside ACCESS and from non-selected slaves.
REQ-031 SHALL NOT accept a new request in DONE; a request present in DONE is taken in the following IDLE cycle.
REQ-032 SHALL treat ack arriving in the same cycle as the timeout as a success (ack wins).
REQ-033 SHALL ignore changes to the CPU inputs while in ACCESS.

Reset
REQ-034 SHALL, while rst=0, immediately force state IDLE, the counter to 0, slv_req_o=0, all slv_* fields 0, the latched rdata/err to 0, and cpu_rdata_o/cpu_err_o to 0.
REQ-035 SHALL, on reset mid-ACCESS, drop the request with no completion; the slave's late ack is ignored.

Structure
REQ-036 SHALL define the state encodings and the default DATA_W/ADDR_W widths in the shared define.v.
REQ-037 SHALL implement address decode (idx plus valid flag) in one sub-module, la_bus_decoder.
REQ-038 SHALL be instantiable in place of the direct CPU-to-RAM connection in the SoC top.

Verification
REQ-039 SHALL cover a read of slave 1: addr 0x1000_0010, ack in the first ACCESS cycle, rdata 0xDEAD_BEEF -> stall 2 cycles, DONE rdata 0xDEAD_BEEF, err 0.
REQ-040 SHALL cover a write to slave 2: sel 4'b0011, wdata 0x1234_5678, ack after 5 cycles -> slv_req_o=4'b0100 for 5 cycles with fields stable, then DONE rdata 0, err 0.
REQ-041 SHALL cover a decode error: NUM_SLV=3, addr 0x3000_0000 -> no slv_req_o, DONE in cycle 1, err 1.
REQ-042 SHALL cover a timeout: TIMEOUT=8, no ack -> slv_req_o high 8 cycles, DONE with err 1 and rdata 0, then req drops.
REQ-043 SHALL cover reset mid-ACCESS: rst low in cycle 3 -> slv_req_o=0 immediately, state IDLE, a subsequent ack produces no completion.
REQ-044 SHALL cover back-to-back requests: cpu_en_i held across DONE -> second access enters ACCESS two cycles after the first DONE.

Source files
------------

// File: rtl/la_data_bus_pkg.sv
// la_data_bus_pkg: shared state encoding and default widths for the CPU data bus.
package la_data_bus_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_t;
endpackage

// File: rtl/la_bus_decoder.sv
// la_bus_decoder: maps the slave-index address field to an index and a valid flag.
module la_bus_decoder #(
  parameter int NUM_SLV = 4,
  localparam int IDX_W = $clog2(NUM_SLV)
) (
  input  logic [IDX_W-1:0] sel_field,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  assign idx = sel_field;
  assign valid = {1'b0, sel_field} < (IDX_W+1)'(NUM_SLV);
endmodule

// File: rtl/la_data_bus.sv
// la_data_bus: routes one CPU data access at a time to an address-selected slave,
// with an ack timeout and a one-cycle completion phase.
module la_data_bus
  import la_data_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en_i,
  input  logic                      cpu_we_i,
  input  logic [ADDR_W-1:0]         cpu_addr_i,
  input  logic [DATA_W/8-1:0]       cpu_sel_i,
  input  logic [DATA_W-1:0]         cpu_wdata_i,
  output logic [DATA_W-1:0]         cpu_rdata_o,
  output logic                      cpu_stall_o,
  output logic                      cpu_err_o,
  output logic [NUM_SLV-1:0]        slv_req_o,
  output logic                      slv_we_o,
  output logic [ADDR_W-1:0]         slv_addr_o,
  output logic [DATA_W/8-1:0]       slv_sel_o,
  output logic [DATA_W-1:0]         slv_wdata_o,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]        slv_ack_i
);
  localparam int IDX_W = $clog2(NUM_SLV);
  bus_state_t state, state_nx;
  logic [IDX_W-1:0] dec_idx, idx_q;
  logic dec_ok, ack, tmo, err_q;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] slv_rd [NUM_SLV];
  la_bus_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
    .sel_field(cpu_addr_i[SEL_LSB +: IDX_W]),
    .idx      (dec_idx),
    .valid    (dec_ok)
  );
  for (genvar k = 0; k < NUM_SLV; k++) begin : g_rd
    assign slv_rd[k] = slv_rdata_i[k*DATA_W +: DATA_W];
  end
  assign ack = slv_ack_i[idx_q];
  assign tmo = cnt == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)   ? (cpu_en_i ? (dec_ok ? ACCESS : DONE) : IDLE) :
               (state == ACCESS) ? ((ack || tmo) ? DONE : ACCESS) : IDLE;
  end
  // Ack is checked before the timeout so an ack on the last wait cycle still succeeds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slv_we_o    <= 1'b0;
      slv_addr_o  <= '0;
      slv_sel_o   <= '0;
      slv_wdata_o <= '0;
      idx_q       <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == IDLE && cpu_en_i) begin
        slv_we_o    <= cpu_we_i;
        slv_addr_o  <= cpu_addr_i;
        slv_sel_o   <= cpu_sel_i;
        slv_wdata_o <= cpu_wdata_i;
        idx_q       <= dec_idx;
        cnt         <= '0;
        rdata_q     <= '0;
        err_q       <= !dec_ok;
      end
      if (state == ACCESS) begin
        cnt <= cnt + CNT_W'(1);
        if (ack) begin
          rdata_q <= slv_we_o ? '0 : slv_rd[idx_q];
          err_q   <= 1'b0;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end
  assign cpu_stall_o = (state == IDLE && cpu_en_i) || state == ACCESS;
  assign cpu_rdata_o = (state == DONE) ? rdata_q : '0;
  assign cpu_err_o   = state == DONE && err_q;
  assign slv_req_o   = (state == ACCESS) ? (NUM_SLV'(1) << idx_q) : '0;
endmodule

// File: tb/tb_la_data_bus.sv
// tb_la_data_bus: randomized and directed checks of la_data_bus against a transaction-level model.
module tb_la_data_bus;
  localparam int NSLV = 3;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst;
  logic cpu_en, cpu_we, cpu_stall, cpu_err, slv_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, slv_addr, slv_wdata;
  logic [3:0] cpu_sel, slv_sel;
  logic [2:0] slv_req, slv_ack;
  logic [95:0] slv_rdata;
  int checks = 0;
  int failures = 0;

  la_data_bus #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(NSLV), .SEL_LSB(28), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cpu_en_i(cpu_en), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_sel_i(cpu_sel),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall), .cpu_err_o(cpu_err),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_addr_o(slv_addr), .slv_sel_o(slv_sel),
    .slv_wdata_o(slv_wdata), .slv_rdata_i(slv_rdata), .slv_ack_i(slv_ack)
  );

  always #5 clk = ~clk;

  // One whole access: dly = ACCESS cycle in which the target slave acks (0 = never).
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wd, input int dly,
                         input logic [31:0] rd, input bit hold_en);
    int idx, n_acc;
    bit hit;
    logic [31:0] exp_rd;
    logic [2:0] exp_req, noise;
    idx = int'(addr[29:28]);
    hit = idx < NSLV && dly >= 1 && dly <= TMO;
    n_acc = (idx >= NSLV) ? 0 : (hit ? dly : TMO);
    exp_rd = (hit && !we) ? rd : 32'h0;
    exp_req = (idx < NSLV) ? 3'(1 << idx) : 3'b000;
    @(negedge clk);
    cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wd;
    slv_ack = 3'($urandom); slv_rdata = {$urandom, $urandom, $urandom};
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || slv_req !== 3'b000 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL %s request: stall=%b req=%b err=%b rdata=%h, want stall=1 req=000 err=0 rdata=0",
               name, cpu_stall, slv_req, cpu_err, cpu_rdata);
    end
    for (int k = 1; k <= n_acc; k++) begin
      @(negedge clk);
      cpu_en = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
      cpu_sel = 4'($urandom); cpu_wdata = $urandom;
      noise = 3'($urandom) & ~exp_req;
      slv_ack = (k == dly) ? (noise | exp_req) : noise;
      slv_rdata = {$urandom, $urandom, $urandom};
      slv_rdata[idx*32 +: 32] = rd;
      #1;
      checks++;
      if (cpu_stall !== 1'b1 || slv_req !== exp_req) begin
        failures++;
        $display("FAIL %s access%0d: stall=%b req=%b, want stall=1 req=%b", name, k, cpu_stall, slv_req, exp_req);
      end
      checks++;
      if ({slv_we, slv_addr, slv_sel, slv_wdata} !== {we, addr, sel, wd}) begin
        failures++;
        $display("FAIL %s fields%0d: we=%b addr=%h sel=%b wdata=%h, want we=%b addr=%h sel=%b wdata=%h",
                 name, k, slv_we, slv_addr, slv_sel, slv_wdata, we, addr, sel, wd);
      end
      checks++;
      if (cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin
        failures++;
        $display("FAIL %s access%0d outputs: err=%b rdata=%h, want 0", name, k, cpu_err, cpu_rdata);
      end
    end
    @(negedge clk);
    cpu_en = hold_en; cpu_we = 1'($urandom); cpu_addr = $urandom; slv_ack = 3'($urandom);
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || slv_req !== 3'b000 || cpu_rdata !== exp_rd || cpu_err !== !hit) begin
      failures++;
      $display("FAIL %s done: stall=%b req=%b rdata=%h err=%b, want stall=0 req=000 rdata=%h err=%b",
               name, cpu_stall, slv_req, cpu_rdata, cpu_err, exp_rd, !hit);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cpu_en = 1'b0; cpu_addr = $urandom; slv_ack = 3'($urandom);
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || slv_req !== 3'b000 || cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin
        failures++;
        $display("FAIL idle: stall=%b req=%b rdata=%h err=%b, want all 0", cpu_stall, slv_req, cpu_rdata, cpu_err);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; cpu_en = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h1000_0000;
    cpu_sel = 4'hf; cpu_wdata = 32'hffff_ffff; slv_ack = 3'b111; slv_rdata = '1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({slv_req, cpu_stall, cpu_err, cpu_rdata} !== 37'h0 || {slv_we, slv_addr, slv_sel, slv_wdata} !== 69'h0) begin
      failures++;
      $display("FAIL reset: req=%b stall=%b err=%b rdata=%h we=%b addr=%h sel=%b wdata=%h, want all 0",
               slv_req, cpu_stall, cpu_err, cpu_rdata, slv_we, slv_addr, slv_sel, slv_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_read_slave1;
    run_txn("read_s1", 1'b0, 32'h1000_0010, 4'hf, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    idle(1);
  endtask

  task automatic test_write_slave2;
    run_txn("write_s2", 1'b1, 32'h2000_0020, 4'b0011, 32'h1234_5678, 5, 32'hCAFE_F00D, 1'b0);
    idle(1);
  endtask

  task automatic test_decode_error;
    run_txn("decode_err", 1'b0, 32'h3000_0000, 4'hf, 32'h0, 1, 32'h5555_AAAA, 1'b0);
    idle(1);
  endtask

  task automatic test_timeout;
    run_txn("timeout", 1'b0, 32'h0000_0100, 4'hf, 32'h0, 0, 32'h7777_7777, 1'b0);
    idle(1);
    run_txn("ack_at_limit", 1'b0, 32'h1000_0200, 4'hf, 32'h0, TMO, 32'h0BAD_CAFE, 1'b0);
    run_txn("ack_too_late", 1'b0, 32'h2000_0300, 4'hf, 32'h0, TMO + 1, 32'h1111_2222, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_sel = 4'hf; slv_ack = 3'b000;
    repeat (3) begin
      @(negedge clk);
      cpu_en = 1'b0; slv_ack = 3'b000;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (slv_req !== 3'b000 || cpu_stall !== 1'b0 || {slv_we, slv_addr, slv_sel, slv_wdata} !== 69'h0) begin
      failures++;
      $display("FAIL reset_mid: req=%b stall=%b addr=%h, want req=000 stall=0 addr=0", slv_req, cpu_stall, slv_addr);
    end
    @(negedge clk);
    rst = 1'b1; slv_ack = 3'b001; slv_rdata[31:0] = 32'h9999_9999;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      slv_ack = 3'b001;
      #1;
      checks++;
      if (cpu_stall !== 1'b0 || slv_req !== 3'b000 || cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin
        failures++;
        $display("FAIL late_ack: stall=%b req=%b rdata=%h err=%b, want all 0", cpu_stall, slv_req, cpu_rdata, cpu_err);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_txn("b2b_first", 1'b0, 32'h1000_0004, 4'hf, 32'h0, 2, 32'hA5A5_0001, 1'b1);
    run_txn("b2b_second", 1'b1, 32'h0000_0008, 4'b1100, 32'hB6B6_0002, 1, 32'h0, 1'b1);
    run_txn("b2b_third", 1'b0, 32'h2000_000c, 4'hf, 32'h0, 3, 32'hC7C7_0003, 1'b0);
    idle(1);
  endtask

  task automatic test_random;
    logic [31:0] addr;
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      addr[31:30] = 2'b00;
      run_txn("random", 1'($urandom), addr, 4'($urandom), $urandom, int'($urandom_range(0, 10)),
              $urandom, (t != 39) && 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_read_slave1;
    test_write_slave2;
    test_decode_error;
    test_timeout;
    test_reset_mid_access;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
